// File: rtl/sha_msg_pad.sv
// SHA-256 message padder: streams raw big-endian words into the core as padded
// 512-bit blocks (0x80 terminator, zero fill, 64-bit bit length).
module sha_msg_pad #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             s_vld,
    input  logic [31:0]      s_din,
    output logic             s_rdy,
    output logic             core_init,
    output logic             core_vld,
    output logic [31:0]      core_din,
    input  logic             core_done,
    output logic             busy,
    output logic             msg_done
);

    // g spans at most 16 words per block over ~2^(LEN_W-6)+2 blocks
    localparam int unsigned G_W = LEN_W + 4;
    localparam int unsigned I_W = G_W + 2;
    localparam int unsigned B_W = LEN_W;
    localparam int unsigned X_W = LEN_W + 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_FEED,
        ST_WAIT
    } state_t;

    state_t           state, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [B_W-1:0]   last_blk_q, last_blk_d;
    logic [G_W-1:0]   g, g_d;
    logic [B_W-1:0]   b, b_d;
    logic             core_init_d, core_vld_d, busy_d, msg_done_d;
    logic [31:0]      core_din_d;

    logic [I_W-1:0]   byte_idx;
    logic [I_W-1:0]   len_ext;
    logic [3:0]       w;
    logic             need_in;
    logic             full_word;
    logic [1:0]       rem;
    logic             last_blk;
    logic [31:0]      bitlen;
    logic [31:0]      pad_word;

    assign byte_idx  = {g, 2'b00};
    assign len_ext   = I_W'(len_q);
    assign w         = g[3:0];
    assign need_in   = byte_idx < len_ext;
    assign full_word = (byte_idx + I_W'(4)) <= len_ext;
    assign rem       = 2'(len_ext - byte_idx);
    assign last_blk  = (b == last_blk_q);
    assign bitlen    = 32'({len_q, 3'b000});

    // Ready depends only on registered state, never on s_vld
    assign s_rdy = (state == ST_FEED) && need_in;

    // Content of output word g
    always_comb begin
        pad_word = 32'h0000_0000;
        if (full_word) begin
            pad_word = s_din;
        end else if (need_in) begin
            case (rem)
                2'd1:    pad_word = {s_din[31:24], 24'h80_0000};
                2'd2:    pad_word = {s_din[31:16], 16'h8000};
                default: pad_word = {s_din[31:8], 8'h80};
            endcase
        end else if (byte_idx == len_ext) begin
            pad_word = 32'h8000_0000;
        end else if (last_blk && (w == 4'hF)) begin
            pad_word = bitlen;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state;
        len_d       = len_q;
        last_blk_d  = last_blk_q;
        g_d         = g;
        b_d         = b;
        core_init_d = 1'b0;
        core_vld_d  = 1'b0;
        core_din_d  = core_din;
        busy_d      = busy;
        msg_done_d  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    len_d       = msg_len;
                    last_blk_d  = B_W'((X_W'(msg_len) + X_W'(8)) >> 6);
                    g_d         = '0;
                    b_d         = '0;
                    busy_d      = 1'b1;
                    core_init_d = 1'b1;
                    state_d     = ST_INIT;
                end
            end
            ST_INIT: begin
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (!need_in || s_vld) begin
                    core_vld_d = 1'b1;
                    core_din_d = pad_word;
                    g_d        = g + G_W'(1);
                    if (w == 4'hF) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    if (last_blk) begin
                        msg_done_d = 1'b1;
                        busy_d     = 1'b0;
                        g_d        = '0;
                        b_d        = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        b_d     = b + B_W'(1);
                        state_d = ST_FEED;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            last_blk_q <= '0;
            g          <= '0;
            b          <= '0;
            core_init  <= 1'b0;
            core_vld   <= 1'b0;
            core_din   <= 32'h0000_0000;
            busy       <= 1'b0;
            msg_done   <= 1'b0;
        end else begin
            state      <= state_d;
            len_q      <= len_d;
            last_blk_q <= last_blk_d;
            g          <= g_d;
            b          <= b_d;
            core_init  <= core_init_d;
            core_vld   <= core_vld_d;
            core_din   <= core_din_d;
            busy       <= busy_d;
            msg_done   <= msg_done_d;
        end
    end

endmodule

// File: doc/sha_msg_pad.md
Name: sha_msg_pad

Overview:
- Upstream feeder for the SHA-256 core.
- Accepts a raw message as a stream of big-endian 32-bit words plus a byte length, and applies SHA-256 padding: 0x80 terminator, zero fill, and a 64-bit bit-length.
- Drives the core's init/vld/din inputs one 512-bit block (16 words) at a time, waiting for the core's done pulse between blocks.
- Lets firmware or a DMA stage hash arbitrary-length messages without computing the padding itself.

Parameters:
- LEN_W, 16: width of the message byte-length input. Legal range 1..29, so the high length word is always 0.

Ports:
- CLK_I  input  1  system clock
- RST_I  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse; latches msg_len and begins a message; ignored while busy=1
- msg_len  input  LEN_W  message length in bytes, sampled on start
- s_vld  input  1  upstream word valid
- s_din  input  32  upstream word; first message byte in [31:24]; unused low bytes of the final partial word are don't-care
- s_rdy  output  1  upstream ready; a transfer occurs when s_vld&s_rdy
- core_init  output  1  one-cycle init pulse to the core (loads Hx)
- core_vld  output  1  one-cycle word-valid pulse to the core
- core_din  output  32  word to the core
- core_done  input  1  core block-complete pulse
- busy  output  1  high from start until msg_done
- msg_done  output  1  one-cycle pulse after the final block's core_done

Behaviour:
- Reset values: s_rdy, core_init, core_vld, busy, msg_done = 0; core_din = 0; FSM = IDLE; all counters = 0.
- Derived values, fixed at start:
  - nwords = ceil(len/4)
  - nblk = floor((len+8)/64)+1
  - bitlen = {len,3'b000}, zero-extended to 32 bits
- Counters:
  - g: global output word index, 0..16*nblk-1
  - w = g[3:0]: word within block
  - b: block index
- Word content for index g (len = latched msg_len):
  - 4g+4 <= len: s_din unchanged.
  - 4g < len < 4g+4, r = len-4g (1..3): keep r high bytes of s_din, byte r = 0x80, remaining bytes 0.
  - 4g == len: 0x80000000.
  - Last block, w=14: 0x00000000 (high length word).
  - Last block, w=15: bitlen.
  - Otherwise: 0.
- FSM states:
  - IDLE: on start, latch len, set busy=1, go to INIT.
  - INIT: core_init=1 for exactly one cycle, go to FEED. core_init is issued once per message only; chaining between blocks is done by the core.
  - FEED: emits one word per cycle.
    - If 4g < len, the word needs input: s_rdy=1 (combinational on state and g only, never on s_vld). The word is emitted only on s_vld&s_rdy.
    - Otherwise the word is generated internally and emitted every cycle; s_rdy=0.
    - Emit means core_vld=1 and core_din = word, both registered: 1-cycle latency from the s_vld&s_rdy cycle to core_vld.
    - After emitting w=15, go to WAIT.
  - WAIT: s_rdy=0, no core_vld. On core_done:
    - If b < nblk-1: increment b, go to FEED.
    - Else: msg_done=1 for one cycle, busy=0, go to IDLE.
- Boundary conditions:
  - len=0: one block, word0 = 0x80000000, no upstream transfers.
  - Padding spans a block boundary when len mod 64 >= 56: the 0x80 falls in block nblk-2 and the length words in block nblk-1.
  - Upstream gaps (s_vld=0) stall FEED with no core_vld; word order is preserved.
  - core_done outside WAIT is ignored.
  - start while busy is ignored; a new message may start in the cycle after msg_done.
  - RST_I mid-message returns to IDLE immediately and drops all outputs. The core must be re-initialised by the next start.
  - Upstream words beyond nwords are never accepted.

Test Plan:
- len=0 → core_init once, then 16 core_vld pulses: word0=0x80000000, words1..15=0; core_done → msg_done; s_rdy never high.
- len=3, s_din=0x616263xx → word0=0x61626380, words1..14=0, word15=0x00000018; exactly one upstream transfer.
- len=55 → 14 transfers; word13 = (s_din & 0xFFFFFF00)|0x80, word14=0, word15=0x000001B8; single block.
- len=56 → block0: 14 transfers, word14=0x80000000, word15=0. No core_vld until core_done is asserted; delay core_done 20 cycles and check. Block1: words0..14=0, word15=0x000001C0; msg_done after the second core_done.
- len=128 with s_vld toggling every other cycle → 32 transfers in order across blocks 0..1; block2 word0=0x80000000, word15=0x00000400; start pulses while busy are ignored.
- Assert RST_I during block1 of a len=100 message → all outputs 0 and FSM=IDLE next edge; a subsequent start with len=3 produces the len=3 response.
